// File: rtl/controle_modo.sv
// controle_modo: lamp mode controller downstream of the auto-shutdown timer.
// It debounces the push-button, classifies each press as short or long, and
// keeps the lamp (led) and mode (modo) state.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-low reset
//   push    in   raw push-button (asynchronous), 1 = pressed
//   infra   in   presence sensor (synchronous), 1 = presence
//   C       in   one-cycle shutdown pulse from the timer
//   led     out  lamp drive, registered
//   modo    out  0 = automatic, 1 = manual, registered
//   enable  out  timer enable, combinational !modo && led
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | debounced button released, waiting for a press
// PRESSED   | button held; hold counts cycles toward the long threshold
// LONG_HELD | long press already acted on; wait for release, hold frozen
module controle_modo #(
    parameter int DEBOUNCE_T = 100,
    parameter int LONG_T     = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic infra,
    input  logic C,
    output logic led,
    output logic modo,
    output logic enable
);

    localparam int DB_W   = $clog2(DEBOUNCE_T) + 1;
    localparam int HOLD_W = $clog2(LONG_T) + 1;
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_T - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_T - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } state_t;

    logic              sync1_q, push_s_q;
    logic              db_q, db_d;
    logic [DB_W-1:0]   cnt_db_q, cnt_db_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              led_q, led_d;
    logic              modo_q, modo_d;
    logic              db_rise, db_fall;
    logic              short_press, long_press;

    always_comb begin
        db_d     = db_q;
        cnt_db_d = cnt_db_q;
        if (push_s_q == db_q) begin
            cnt_db_d = '0;
        end else if (cnt_db_q == DB_MAX) begin
            db_d     = push_s_q;
            cnt_db_d = '0;
        end else begin
            cnt_db_d = cnt_db_q + 1'b1;
        end
    end

    // Edges are taken from the value being loaded into db so the FSM reacts
    // at the same edge db changes, not one cycle later.
    assign db_rise = db_d & ~db_q;
    assign db_fall = ~db_d & db_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        short_press = 1'b0;
        long_press  = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_rise) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                hold_d = hold_q + 1'b1;
                if (db_fall) begin
                    short_press = 1'b1;
                    state_d     = IDLE;
                end else if (hold_q == HOLD_MAX) begin
                    long_press = 1'b1;
                    state_d    = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (db_fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Priority: long-press mode toggle > short-press toggle (manual only)
    // > C > infra (automatic only).
    always_comb begin
        led_d  = led_q;
        modo_d = modo_q;
        if (long_press) begin
            modo_d = ~modo_q;
        end else if (short_press && modo_q) begin
            led_d = ~led_q;
        end else if (!modo_q) begin
            if (C) begin
                led_d = 1'b0;
            end else if (infra) begin
                led_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            push_s_q <= 1'b0;
            db_q     <= 1'b0;
            cnt_db_q <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            led_q    <= 1'b0;
            modo_q   <= 1'b0;
        end else begin
            sync1_q  <= push;
            push_s_q <= sync1_q;
            db_q     <= db_d;
            cnt_db_q <= cnt_db_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
            modo_q   <= modo_d;
        end
    end

    assign led    = led_q;
    assign modo   = modo_q;
    assign enable = ~modo_q & led_q;

endmodule

// File: tb/tb_controle_modo.sv
// Bench for controle_modo with DEBOUNCE_T=4, LONG_T=20. Stimulus queues
// cycle-tagged expectations; a negedge monitor checks them as cycles arrive.
module tb_controle_modo;

    localparam int DT = 4;
    localparam int LT = 20;

    logic clk = 1'b0;
    logic rst, push, infra, C;
    logic led, modo, enable;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int   cyc;
        int   sel;
        logic val;
        int   tag;
    } exp_t;

    exp_t sb[$];

    controle_modo #(.DEBOUNCE_T(DT), .LONG_T(LT)) dut (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .infra  (infra),
        .C      (C),
        .led    (led),
        .modo   (modo),
        .enable (enable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_sig(input int c, input int sel, input logic v, input int tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void exp_out(input int c, input logic l, input logic m, input int tag);
        exp_sig(c, 0, l, tag);
        exp_sig(c, 1, m, tag);
        exp_sig(c, 2, !m && l, tag);
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            0: return "led";
            1: return "modo";
            2: return "enable";
            default: return "db";
        endcase
    endfunction

    function automatic logic actual(input int sel);
        case (sel)
            0: return led;
            1: return modo;
            2: return enable;
            default: return dut.db_q;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic a;
                a = actual(sb[i].sel);
                total++;
                if (a !== sb[i].val) begin
                    bad++;
                    $display("FAIL t%0d %s cyc=%0d got=%0b want=%0b",
                             sb[i].tag, sig_name(sb[i].sel), cyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #(10 * 3000);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        push  = 1'b1;
        infra = 1'b1;
        C     = 1'b0;

        // 1: reset with push and infra held; release, held push is a new long press
        exp_out(1, 0, 0, 1);
        exp_out(2, 0, 0, 1);
        exp_out(3, 1, 0, 1);
        exp_sig(7, 3, 1'b0, 1);
        exp_sig(8, 3, 1'b1, 1);
        exp_out(27, 1, 0, 1);
        exp_out(28, 1, 1, 1);
        exp_sig(35, 3, 1'b1, 1);
        exp_sig(36, 3, 1'b0, 1);
        exp_out(36, 1, 1, 1);
        at_neg(2);
        rst = 1'b1;
        at_neg(3);
        total++;
        if (led !== 1'b1) begin
            bad++;
            $display("FAIL t1 direct led cyc=%0d got=%0b want=1", cyc, led);
        end
        total++;
        if (modo !== 1'b0) begin
            bad++;
            $display("FAIL t1 direct modo cyc=%0d got=%0b want=0", cyc, modo);
        end
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL t1 direct enable cyc=%0d got=%0b want=1", cyc, enable);
        end
        at_neg(28);
        total++;
        if (modo !== 1'b1) begin
            bad++;
            $display("FAIL t1 direct modo cyc=%0d got=%0b want=1", cyc, modo);
        end
        total++;
        if (led !== 1'b1) begin
            bad++;
            $display("FAIL t1 direct led cyc=%0d got=%0b want=1", cyc, led);
        end
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL t1 direct enable cyc=%0d got=%0b want=0", cyc, enable);
        end
        at_neg(30);
        push = 1'b0;

        // 3: manual short presses; C/infra ignored in manual
        at_neg(40);
        exp_out(45, 1, 1, 3);
        exp_out(46, 1, 1, 3);
        exp_out(53, 1, 1, 3);
        exp_out(54, 0, 1, 3);
        exp_out(73, 0, 1, 3);
        exp_out(74, 1, 1, 3);
        push  = 1'b1;
        infra = 1'b1;
        at_neg(44);
        C = 1'b1;
        at_neg(45);
        C = 1'b0;
        at_neg(48);
        push = 1'b0;
        at_neg(60);
        push = 1'b1;
        at_neg(68);
        push = 1'b0;

        // long press back to automatic, led kept, enable rises at once
        at_neg(75);
        infra = 1'b0;
        exp_out(105, 1, 1, 4);
        exp_out(106, 1, 0, 4);
        exp_out(126, 1, 0, 4);
        at_neg(80);
        push = 1'b1;
        at_neg(120);
        push = 1'b0;

        // 4: long press from automatic with led=1, held 40 cycles
        at_neg(128);
        exp_sig(135, 3, 1'b0, 4);
        exp_sig(136, 3, 1'b1, 4);
        exp_out(155, 1, 0, 4);
        exp_out(156, 1, 1, 4);
        exp_out(175, 1, 1, 4);
        exp_sig(176, 3, 1'b0, 4);
        exp_out(176, 1, 1, 4);
        exp_out(177, 1, 1, 4);
        exp_out(205, 1, 1, 4);
        exp_out(206, 1, 0, 4);
        exp_out(216, 1, 0, 4);
        at_neg(130);
        push = 1'b1;
        at_neg(170);
        push = 1'b0;
        at_neg(180);
        push = 1'b1;
        at_neg(210);
        push = 1'b0;

        // 5: C pulse clears led in automatic
        at_neg(218);
        exp_out(220, 1, 0, 5);
        exp_out(221, 0, 0, 5);
        exp_out(222, 0, 0, 5);
        at_neg(220);
        C = 1'b1;
        at_neg(221);
        C = 1'b0;
        total++;
        if (led !== 1'b0) begin
            bad++;
            $display("FAIL t5 direct led cyc=%0d got=%0b want=0", cyc, led);
        end
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL t5 direct enable cyc=%0d got=%0b want=0", cyc, enable);
        end

        // 6: C and infra together, C wins; infra re-sets next edge
        at_neg(224);
        exp_out(226, 1, 0, 6);
        exp_out(229, 1, 0, 6);
        exp_out(230, 0, 0, 6);
        exp_out(231, 1, 0, 6);
        at_neg(225);
        infra = 1'b1;
        at_neg(229);
        C = 1'b1;
        at_neg(230);
        C = 1'b0;

        // 2: bounce, then settle high; db rises exactly 6 edges later
        at_neg(235);
        for (int c = 240; c < 266; c++) exp_sig(c, 3, 1'b0, 2);
        exp_sig(266, 3, 1'b1, 2);
        exp_sig(276, 3, 1'b0, 2);
        exp_out(266, 1, 0, 2);
        exp_out(277, 1, 0, 2);
        for (int k = 0; k < 10; k++) begin
            at_neg(240 + 2 * k);
            push = (k % 2 == 0);
        end
        at_neg(260);
        push = 1'b1;
        at_neg(270);
        push = 1'b0;

        at_neg(290);
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL t%0d %s never_checked cyc=%0d want=%0b",
                     sb[0].tag, sig_name(sb[0].sel), sb[0].cyc, sb[0].val);
            sb.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
